// File: rtl/tank_pkg.sv
// Shared definitions for the tank level model and its supervisor: state
// encoding, height width and the default hysteresis marks.
package tank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_READY = 2'd2,
      ST_FAULT = 2'd3
   } tank_state_t;

   localparam int HEIGHT_W          = 8;
   localparam int DEFAULT_LOW_MARK  = 40;
   localparam int DEFAULT_HIGH_MARK = 90;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (dominant), increment enable and
// saturation at all-ones.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/tank_level_controller.sv
// Fill/serve hysteresis supervisor for the tank level model, with error
// debouncing, a fill timeout and a latched alarm cleared by software.
module tank_level_controller
   import tank_pkg::*;
#(
   parameter int LOW_MARK     = DEFAULT_LOW_MARK,
   parameter int HIGH_MARK    = DEFAULT_HIGH_MARK,
   parameter int ERR_DEBOUNCE = 3,
   parameter int FILL_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [HEIGHT_W-1:0] height,
   input  logic                error,
   input  logic                enable,
   input  logic                demand,
   input  logic                clear_alarm,
   output logic                fill,
   output logic                consume,
   output logic                alarm,
   output logic [1:0]          state,
   output logic [7:0]          fill_timer
);

   localparam int ERR_W = 4;
   localparam logic [HEIGHT_W-1:0] LOW_H  = HEIGHT_W'(LOW_MARK);
   localparam logic [HEIGHT_W-1:0] HIGH_H = HEIGHT_W'(HIGH_MARK);

   generate
      if (LOW_MARK >= HIGH_MARK) begin : g_bad_marks
         $error("tank_level_controller: LOW_MARK must be below HIGH_MARK");
      end
   endgenerate

   tank_state_t      r_state;
   tank_state_t      w_nxt;
   logic             r_fill;
   logic             r_consume;
   logic             r_alarm;
   logic [7:0]       w_fill_timer;
   logic [ERR_W-1:0] w_err_cnt;
   logic             w_err_qual;
   logic             w_timed_out;
   logic             w_debounced;
   logic             w_fill_entry;

   // Both fault tests look at the count including the current cycle, so the
   // fault lands on the edge that samples the Nth qualifying cycle.
   assign w_err_qual   = (r_state == ST_READY) && error;
   assign w_debounced  = w_err_qual && ((int'(w_err_cnt) + 1) >= ERR_DEBOUNCE);
   assign w_timed_out  = (r_state == ST_FILL) && ((int'(w_fill_timer) + 1) >= FILL_TIMEOUT);
   assign w_fill_entry = (r_state != ST_FILL) && (w_nxt == ST_FILL);

   always_comb begin
      w_nxt = r_state;
      if (w_timed_out || w_debounced) begin
         w_nxt = ST_FAULT;
      end else if (r_state == ST_FAULT) begin
         if (clear_alarm && !error) w_nxt = ST_IDLE;
      end else if (!enable) begin
         w_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  w_nxt = ST_FILL;
            ST_FILL:  if (height >= HIGH_H) w_nxt = ST_READY;
            ST_READY: if (height < LOW_H) w_nxt = ST_FILL;
            default:  w_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_fill    <= 1'b0;
         r_consume <= 1'b0;
         r_alarm   <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_fill    <= (w_nxt == ST_FILL);
         r_consume <= (w_nxt == ST_READY) && demand;
         r_alarm   <= (w_nxt == ST_FAULT);
      end
   end

   sat_counter #(.WIDTH(8)) u_fill_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_fill_entry),
      .i_inc   (r_state == ST_FILL),
      .o_count (w_fill_timer)
   );

   sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (!w_err_qual),
      .i_inc   (w_err_qual),
      .o_count (w_err_cnt)
   );

   assign fill       = r_fill;
   assign consume    = r_consume;
   assign alarm      = r_alarm;
   assign state      = r_state;
   assign fill_timer = w_fill_timer;

endmodule
